// File: rtl/rf_wb_arbiter_pkg.sv
// Register-file sizing shared by the writeback path.
// Also holds the index-width helper used to size requester indices.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bundle plus the registered register-file write port.
// The arbiter takes the slave view; the writeback sources take the master view.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int N    = XLEN,
    parameter int NREQ = 3
);
    localparam int IW = idx_width(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [REG_ADDR_W*NREQ-1:0] req_rd;
    logic [N*NREQ-1:0]          req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       wb_hold;
    logic                       rf_we;
    logic [REG_ADDR_W-1:0]      rf_rd;
    logic [N-1:0]               rf_wdata;
    logic [IW-1:0]              grant_id;
    logic                       collision;

    modport slave (
        input  req_valid, req_rd, req_data, wb_hold,
        output req_ready, rf_we, rf_rd, rf_wdata, grant_id, collision
    );

    modport master (
        output req_valid, req_rd, req_data, wb_hold,
        input  req_ready, rf_we, rf_rd, rf_wdata, grant_id, collision
    );
endinterface

// File: rtl/rf_wb_arbiter_chk.sv
// Protocol checker: at most one requester is accepted in any cycle.
module rf_wb_arbiter_chk #(
    parameter int NREQ = 3
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] req_ready_i
);
    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_i))
        else $error("req_ready not one-hot or zero: %b", req_ready_i);
endmodule

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin grant: the first valid requester at or after the pointer wins.
// The pointer moves past the winner only when a grant is issued.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid_i,
    input  logic            hold_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            grant_any_o
);
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idx_s;

    // Grant selection and next pointer; nothing is granted while reset or hold is high
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        idx_s       = '0;
        ptr_d       = ptr_q;
        if (!rst && !hold_i) begin
            for (int k = 0; k < NREQ; k++) begin
                if ((int'(ptr_q) + k) >= NREQ) begin
                    idx_s = IW'(int'(ptr_q) + k - NREQ);
                end else begin
                    idx_s = IW'(int'(ptr_q) + k);
                end
                if (!grant_any_o && valid_i[idx_s]) begin
                    grant_any_o = 1'b1;
                    grant_o[idx_s] = 1'b1;
                    grant_idx_o = idx_s;
                end else begin
                    grant_any_o = grant_any_o;
                end
            end
        end else begin
            grant_o = '0;
        end
        if (grant_any_o) begin
            if (int'(grant_idx_o) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources.
// Registers the winning write; x0 targets are acknowledged but never enabled.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N    = XLEN,
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus
);
    localparam int IW = idx_width(NREQ);

    logic [NREQ-1:0]       grant_s;
    logic [IW-1:0]         gidx_s;
    logic                  xfer_s;
    logic [REG_ADDR_W-1:0] sel_rd_s;
    logic [N-1:0]          sel_data_s;
    logic                  coll_s;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_rd_q;
    logic [N-1:0]          rf_wdata_q;
    logic [IW-1:0]         grant_id_q;
    logic                  coll_q;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (bus.req_valid),
        .hold_i      (bus.wb_hold),
        .grant_o     (grant_s),
        .grant_idx_o (gidx_s),
        .grant_any_o (xfer_s)
    );

    // Winner's rd/data mux
    always_comb begin
        sel_rd_s   = bus.req_rd[REG_ADDR_W*int'(gidx_s) +: REG_ADDR_W];
        sel_data_s = bus.req_data[N*int'(gidx_s) +: N];
    end

    // Same nonzero rd from two valid requesters; evaluated regardless of hold
    always_comb begin
        coll_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (bus.req_valid[i] && bus.req_valid[j] &&
                    (bus.req_rd[REG_ADDR_W*i +: REG_ADDR_W] ==
                     bus.req_rd[REG_ADDR_W*j +: REG_ADDR_W]) &&
                    (bus.req_rd[REG_ADDR_W*i +: REG_ADDR_W] != {REG_ADDR_W{1'b0}})) begin
                    coll_s = 1'b1;
                end else begin
                    coll_s = coll_s;
                end
            end
        end
    end

    // Output register: enable pulses only on a transfer, the rest holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            coll_q <= coll_s;
            if (xfer_s) begin
                rf_we_q    <= (sel_rd_s != {REG_ADDR_W{1'b0}});
                rf_rd_q    <= sel_rd_s;
                rf_wdata_q <= sel_data_s;
                grant_id_q <= gidx_s;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.collision = coll_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_wb_arbiter_if #(.N(32), .NREQ(3)) bus_if ();

    rf_wb_arbiter #(.N(32), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    rf_wb_arbiter_chk #(.NREQ(3)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .req_ready_i (bus_if.req_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        bus_if.req_rd[5*i +: 5]    = rd;
        bus_if.req_data[32*i +: 32] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic [1:0] gid);
        chk({tag, "_we"},    64'(bus_if.rf_we),    64'(we));
        chk({tag, "_rd"},    64'(bus_if.rf_rd),    64'(rd));
        chk({tag, "_wdata"}, 64'(bus_if.rf_wdata), 64'(data));
        chk({tag, "_gid"},   64'(bus_if.grant_id), 64'(gid));
    endtask

    initial begin
        logic [2:0] exp_ready;
        logic       seen0;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.wb_hold   = 1'b0;
        bus_if.req_valid = 3'b111;
        set_req(0, 5'd1, 32'h0000_0011);
        set_req(1, 5'd2, 32'h0000_0022);
        set_req(2, 5'd3, 32'h0000_0033);
        #1;
        chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
        chk_out("rst", 1'b0, 5'd0, 32'd0, 2'd0);
        chk("rst_coll", 64'(bus_if.collision), 64'd0);
        tick();
        tick();
        chk("rst_ready2", 64'(bus_if.req_ready), 64'd0);
        chk("rst_we2", 64'(bus_if.rf_we), 64'd0);

        // First transfer after reset: requester 0, pointer moves to 1
        rst = 1'b0;
        bus_if.req_valid = 3'b001;
        set_req(0, 5'd5, 32'hAAAA_0001);
        #1;
        chk("first_ready", 64'(bus_if.req_ready), 64'd1);
        tick();
        chk_out("first", 1'b1, 5'd5, 32'hAAAA_0001, 2'd0);

        // Hold: requester 2 blocked for 3 cycles, then granted; pointer moves to 0
        bus_if.req_valid = 3'b100;
        bus_if.wb_hold   = 1'b1;
        set_req(2, 5'd7, 32'h0000_1234);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_ready", 64'(bus_if.req_ready), 64'd0);
            tick();
            chk("hold_we", 64'(bus_if.rf_we), 64'd0);
        end
        bus_if.wb_hold = 1'b0;
        #1;
        chk("unhold_ready", 64'(bus_if.req_ready), 64'b100);
        tick();
        chk_out("unhold", 1'b1, 5'd7, 32'h0000_1234, 2'd2);

        // Round robin over all three requesters
        bus_if.req_valid = 3'b111;
        set_req(0, 5'd1, 32'hD000_0000);
        set_req(1, 5'd2, 32'hD000_0001);
        set_req(2, 5'd3, 32'hD000_0002);
        for (int c = 0; c < 6; c++) begin
            exp_ready = 3'b001 << (c % 3);
            #1;
            chk("rr_ready", 64'(bus_if.req_ready), 64'(exp_ready));
            tick();
            chk_out("rr", 1'b1, 5'(c % 3 + 1), 32'hD000_0000 + 32'(c % 3), 2'(c % 3));
            chk("rr_coll", 64'(bus_if.collision), 64'd0);
        end

        // x0 write by requester 1
        bus_if.req_valid = 3'b010;
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk("x0_ready", 64'(bus_if.req_ready), 64'b010);
        tick();
        chk_out("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 2'd1);
        set_req(1, 5'd2, 32'hD000_0001);
        bus_if.req_valid = 3'b111;
        #1;
        chk("x0_ptr2", 64'(bus_if.req_ready), 64'b100);

        // Collision: 0 and 1 both target rd 9; pointer at 2 so 0 lands first
        bus_if.req_valid = 3'b011;
        set_req(0, 5'd9, 32'hC0C0_0000);
        set_req(1, 5'd9, 32'hC1C1_1111);
        #1;
        chk("coll_ready0", 64'(bus_if.req_ready), 64'b001);
        tick();
        chk("coll_pulse", 64'(bus_if.collision), 64'd1);
        chk_out("coll0", 1'b1, 5'd9, 32'hC0C0_0000, 2'd0);
        bus_if.req_valid = 3'b010;
        #1;
        chk("coll_ready1", 64'(bus_if.req_ready), 64'b010);
        tick();
        chk("coll_clear", 64'(bus_if.collision), 64'd0);
        chk_out("coll1", 1'b1, 5'd9, 32'hC1C1_1111, 2'd1);

        // Fairness: pointer at 2, requester 2 wins first, 0 must follow within 3 cycles
        bus_if.req_valid = 3'b101;
        set_req(0, 5'd10, 32'h0000_00A0);
        set_req(2, 5'd12, 32'h0000_00C0);
        #1;
        chk("fair_first", 64'(bus_if.req_ready), 64'b100);
        seen0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (!seen0 && bus_if.req_ready[0]) begin
                seen0 = 1'b1;
            end
        end
        chk("fair_grant0", 64'(seen0), 64'd1);

        // Reset mid-operation drops the latched write and clears the pointer
        bus_if.req_valid = 3'b110;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_we", 64'(bus_if.rf_we), 64'd0);
        chk("midrst_ready", 64'(bus_if.req_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_ready", 64'(bus_if.req_ready), 64'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
